// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with per-pin direction/output, set/clear writes, input synchronisers, edge capture and level irq
// Ports: clk, rst (async active-low); vproc_mem_req_o/addr_o/we_o/be_o/wdata_o request from core;
//        vproc_mem_rvalid_i/err_i/rdata_i response one cycle after each hit; pin_i raw pads;
//        pin_o/pin_oe pad drive values and enables; irq_o high while any captured event is pending.
module gpio_bank #(
  parameter int          NUM_PINS    = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vproc_mem_req_o,
  input  logic [31:0]         vproc_mem_addr_o,
  input  logic                vproc_mem_we_o,
  input  logic [3:0]          vproc_mem_be_o,
  input  logic [31:0]         vproc_mem_wdata_o,
  output logic                vproc_mem_rvalid_i,
  output logic                vproc_mem_err_i,
  output logic [31:0]         vproc_mem_rdata_i,
  input  logic [NUM_PINS-1:0] pin_i,
  output logic [NUM_PINS-1:0] pin_o,
  output logic [NUM_PINS-1:0] pin_oe,
  output logic                irq_o
);
  localparam logic [31:0] PMASK = 32'((64'd1 << NUM_PINS) - 64'd1);
  logic [31:0] dir_q, dir_d, out_q, out_d, ren_q, ren_d, fen_q, fen_d, evt_q, evt_d;
  logic [31:0] rdata_q, rdata_d, bm, wv, in_w, prev_w, edges;
  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] prev_q;
  logic rvalid_q, err_q, irq_q, hit, err, wr, rd;
  logic [2:0] off;
  // BASE_ADDR is 32-byte aligned, so the window is a match on the upper address bits
  assign hit = vproc_mem_req_o && vproc_mem_addr_o[31:5] == BASE_ADDR[31:5];
  assign off = vproc_mem_addr_o[4:2];
  // misaligned, write to IN, or read of SET/CLR
  assign err = |vproc_mem_addr_o[1:0] || (vproc_mem_we_o ? off == 3'd2 : off[2:1] == 2'b11);
  assign wr = hit && vproc_mem_we_o && !err;
  assign rd = hit && !vproc_mem_we_o && !err;
  assign bm = {{8{vproc_mem_be_o[3]}}, {8{vproc_mem_be_o[2]}}, {8{vproc_mem_be_o[1]}}, {8{vproc_mem_be_o[0]}}} & PMASK;
  assign wv = vproc_mem_wdata_o & bm;
  assign in_w = 32'(sync_q[SYNC_STAGES-1]);
  assign prev_w = 32'(prev_q);
  assign edges = (in_w & ~prev_w & ren_q) | (~in_w & prev_w & fen_q);
  always_comb begin
    dir_d = wr && off == 3'd0 ? (dir_q & ~bm) | wv : dir_q;
    out_d = !wr ? out_q : off == 3'd1 ? (out_q & ~bm) | wv : off == 3'd6 ? out_q | wv : off == 3'd7 ? out_q & ~wv : out_q;
    ren_d = wr && off == 3'd3 ? (ren_q & ~bm) | wv : ren_q;
    fen_d = wr && off == 3'd4 ? (fen_q & ~bm) | wv : fen_q;
    // a fresh edge wins over a same-cycle W1C of that bit
    evt_d = (evt_q & ~(wr && off == 3'd5 ? wv : 32'd0)) | edges;
    rdata_d = !rd ? 32'd0 : off == 3'd0 ? dir_q : off == 3'd1 ? out_q : off == 3'd2 ? in_w :
              off == 3'd3 ? ren_q : off == 3'd4 ? fen_q : off == 3'd5 ? evt_q : 32'd0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q <= '0;
      out_q <= '0;
      ren_q <= '0;
      fen_q <= '0;
      evt_q <= '0;
      rdata_q <= '0;
      prev_q <= '0;
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
      irq_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      dir_q <= dir_d;
      out_q <= out_d;
      ren_q <= ren_d;
      fen_q <= fen_d;
      evt_q <= evt_d;
      rdata_q <= rdata_d;
      prev_q <= sync_q[SYNC_STAGES-1];
      rvalid_q <= hit;
      err_q <= hit && err;
      irq_q <= |evt_q;
      sync_q[0] <= pin_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign vproc_mem_rvalid_i = rvalid_q;
  assign vproc_mem_err_i = err_q;
  assign vproc_mem_rdata_i = rdata_q;
  assign pin_oe = dir_q[NUM_PINS-1:0];
  assign pin_o = out_q[NUM_PINS-1:0] & dir_q[NUM_PINS-1:0];
  assign irq_o = irq_q;
endmodule
